// File: rtl/mux_pkg.sv
// Shared definitions for the mux arbiter family: FSM state encoding and
// the elaboration-time legality check on the burst length.
package mux_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // A burst must be 1..255 and representable in a cw-bit beat counter.
    function automatic bit burst_ok(input int burst, input int cw);
        return (burst >= 1) && (burst <= 255) && (cw >= 1) && (cw < 31) &&
               (burst <= ((1 << cw) - 1));
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way priority pick: the sole requester wins, or prio breaks a tie.
module rr_pick2
    import mux_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       any,
    output logic       winner
);

    always_comb begin
        any    = |req;
        winner = (req == 2'b11) ? prio : req[1];
    end

endmodule

// File: rtl/mux_2x1_rr_arbiter.sv
// Round-robin arbiter with bounded bursts driving a registered mux select
// and a valid/ready handshake for the downstream stage.
module mux_2x1_rr_arbiter
    import mux_pkg::*;
#(
    parameter int BURST = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       out_ready,
    output logic       sel,
    output logic [1:0] gnt,
    output logic       out_valid,
    output logic       beat_done
);

    generate
        if (!burst_ok(BURST, CW)) begin : g_bad_burst
            $error("mux_2x1_rr_arbiter: BURST out of range for CW");
        end
    endgenerate

    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

    state_t          state_reg, state_next;
    logic [1:0]      gnt_reg, gnt_next;
    logic            sel_reg, sel_next;
    logic            prio_reg, prio_next;
    logic [CW-1:0]   cnt_reg, cnt_next;

    logic            pick_any;
    logic            pick_winner;
    logic [1:0]      pick_onehot;

    rr_pick2 u_pick (
        .req    (req),
        .prio   (prio_reg),
        .any    (pick_any),
        .winner (pick_winner)
    );

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick_winner == 1'(gi));
        end
    endgenerate

    assign out_valid = |(gnt_reg & req);
    assign beat_done = out_valid & out_ready;
    assign gnt       = gnt_reg;
    assign sel       = sel_reg;

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        prio_next  = prio_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    state_next = ST_GRANT;
                    gnt_next   = pick_onehot;
                    sel_next   = pick_winner;
                    cnt_next   = '0;
                end
            end
            ST_GRANT: begin
                // A dropped request ends the grant without counting a beat.
                if (!out_valid) begin
                    state_next = ST_IDLE;
                    gnt_next   = 2'b00;
                    prio_next  = ~sel_reg;
                    cnt_next   = '0;
                end else if (out_ready) begin
                    if (cnt_reg == LAST_BEAT) begin
                        state_next = ST_IDLE;
                        gnt_next   = 2'b00;
                        prio_next  = ~sel_reg;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                gnt_next   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= 2'b00;
            sel_reg   <= 1'b0;
            prio_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            sel_reg   <= sel_next;
            prio_reg  <= prio_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_mux_2x1_rr_arbiter.sv
// Directed bench for mux_2x1_rr_arbiter: an ownership/beat-count model is
// compared every cycle, plus literal expectations for each scenario.
module tb_mux_2x1_rr_arbiter;

    localparam int BURST = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic       out_ready = 1'b0;
    logic       sel;
    logic [1:0] gnt;
    logic       out_valid;
    logic       beat_done;

    int total = 0;
    int bad   = 0;

    mux_2x1_rr_arbiter #(.BURST(BURST), .CW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt       (gnt),
        .out_valid (out_valid),
        .beat_done (beat_done)
    );

    always #5 clk = ~clk;

    // Model: who owns the mux (-1 = nobody), how many beats it has moved,
    // which source was last selected and who is preferred on a tie.
    int m_owner = -1;
    int m_beats = 0;
    int m_sel   = 0;
    int m_prio  = 0;
    bit model_ok = 1'b0;

    function automatic int pick(input logic [1:0] r, input int p);
        if (r == 2'b11) return p;
        return r[1] ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner  <= -1;
            m_beats  <= 0;
            m_sel    <= 0;
            m_prio   <= 0;
            model_ok <= 1'b1;
        end else if (m_owner < 0) begin
            if (req != 2'b00) begin
                m_owner <= pick(req, m_prio);
                m_sel   <= pick(req, m_prio);
                m_beats <= 0;
            end
        end else if (!req[m_owner]) begin
            m_owner <= -1;
            m_prio  <= 1 - m_sel;
        end else if (out_ready) begin
            if (m_beats + 1 == BURST) begin
                m_owner <= -1;
                m_prio  <= 1 - m_sel;
                m_beats <= 0;
            end else begin
                m_beats <= m_beats + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            int e_valid;
            e_valid = (m_owner >= 0 && req[m_owner]) ? 1 : 0;
            chk("model_gnt", int'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
            chk("model_sel", int'(sel), m_sel);
            chk("model_valid", int'(out_valid), e_valid);
            chk("model_beat", int'(beat_done), e_valid & int'(out_ready));
        end
    end

    // Inputs change 2 time units after the rising edge; returns at the
    // following falling edge so the caller can inspect the outputs.
    task automatic tick(input logic r_rst, input logic [1:0] r, input logic rdy);
        @(posedge clk);
        #2;
        rst       = r_rst;
        req       = r;
        out_ready = rdy;
        @(negedge clk);
    endtask

    logic [9:0]  bd_hist;
    logic [10:0] sel_hist;
    logic [10:0] val_hist;

    initial begin
        // Reset then idle
        tick(1'b1, 2'b00, 1'b0);
        tick(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 2'b00, 1'b1);
            chk("idle_gnt", int'(gnt), 0);
            chk("idle_sel", int'(sel), 0);
            chk("idle_valid", int'(out_valid), 0);
        end

        // Single source 1: 4 beats on, 1 bubble, regrant
        tick(1'b0, 2'b10, 1'b1);
        chk("single_latency_gnt", int'(gnt), 0);
        bd_hist = '0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 2'b10, 1'b1);
            if (i == 0) begin
                chk("single_gnt", int'(gnt), 2);
                chk("single_sel", int'(sel), 1);
            end
            bd_hist = {bd_hist[8:0], beat_done};
        end
        chk("single_pattern", int'(bd_hist), int'(10'b1111011110));
        for (int i = 0; i < 3; i++) tick(1'b0, 2'b00, 1'b1);

        // Contention with both sources requesting
        tick(1'b0, 2'b11, 1'b1);
        sel_hist = '0;
        val_hist = '0;
        for (int i = 0; i < 11; i++) begin
            tick(1'b0, 2'b11, 1'b1);
            sel_hist = {sel_hist[9:0], sel};
            val_hist = {val_hist[9:0], out_valid};
        end
        chk("contend_sel_seq", int'(sel_hist), int'(11'b00000111110));
        chk("contend_valid_seq", int'(val_hist), int'(11'b11110111101));
        for (int i = 0; i < 3; i++) tick(1'b0, 2'b00, 1'b1);

        // Backpressure on source 0 after beat 2
        tick(1'b0, 2'b01, 1'b1);
        tick(1'b0, 2'b01, 1'b1);
        chk("bp_beat1", int'(beat_done), 1);
        tick(1'b0, 2'b01, 1'b1);
        chk("bp_beat2", int'(beat_done), 1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 2'b01, 1'b0);
            chk("bp_stall_valid", int'(out_valid), 1);
            chk("bp_stall_beat", int'(beat_done), 0);
            chk("bp_stall_sel", int'(sel), 0);
        end
        tick(1'b0, 2'b01, 1'b1);
        chk("bp_beat3", int'(beat_done), 1);
        tick(1'b0, 2'b01, 1'b1);
        chk("bp_beat4", int'(beat_done), 1);
        tick(1'b0, 2'b00, 1'b1);
        chk("bp_release_gnt", int'(gnt), 0);
        for (int i = 0; i < 2; i++) tick(1'b0, 2'b00, 1'b1);

        // Short grant to source 1 so the tie goes to source 0 next
        tick(1'b0, 2'b10, 1'b1);
        tick(1'b0, 2'b00, 1'b1);
        tick(1'b0, 2'b00, 1'b1);
        tick(1'b0, 2'b00, 1'b1);

        // Early drop: source 0 lets go after beat 1
        tick(1'b0, 2'b11, 1'b1);
        tick(1'b0, 2'b11, 1'b1);
        chk("drop_gnt0", int'(gnt), 1);
        chk("drop_beat1", int'(beat_done), 1);
        tick(1'b0, 2'b10, 1'b1);
        chk("drop_no_valid", int'(out_valid), 0);
        tick(1'b0, 2'b10, 1'b1);
        chk("drop_release", int'(gnt), 0);
        tick(1'b0, 2'b10, 1'b1);
        chk("drop_gnt1", int'(gnt), 2);
        chk("drop_sel1", int'(sel), 1);
        tick(1'b0, 2'b00, 1'b1);
        tick(1'b0, 2'b00, 1'b1);
        tick(1'b0, 2'b00, 1'b1);

        // Reset in the middle of a grant to source 1
        tick(1'b0, 2'b10, 1'b1);
        tick(1'b0, 2'b10, 1'b1);
        tick(1'b0, 2'b10, 1'b1);
        tick(1'b1, 2'b10, 1'b1);
        chk("rst_mid_beat_before", int'(beat_done), 1);
        tick(1'b0, 2'b11, 1'b1);
        chk("rst_mid_gnt", int'(gnt), 0);
        chk("rst_mid_sel", int'(sel), 0);
        chk("rst_mid_beat", int'(beat_done), 0);
        tick(1'b0, 2'b11, 1'b1);
        chk("rst_prio_gnt", int'(gnt), 1);
        tick(1'b0, 2'b00, 1'b1);
        tick(1'b0, 2'b00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
